// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - ALU function codes and arbiter state encoding
package alu_share_arbiter_pkg;

    localparam int ALU_W = 32;

    // ALU function codes (3-bit field, all eight codes defined)
    localparam logic [2:0] FNC_ADD_SUB = 3'b000;
    localparam logic [2:0] FNC_SLL     = 3'b001;
    localparam logic [2:0] FNC_SLT     = 3'b010;
    localparam logic [2:0] FNC_SLTU    = 3'b011;
    localparam logic [2:0] FNC_XOR     = 3'b100;
    localparam logic [2:0] FNC_SRL_SRA = 3'b101;
    localparam logic [2:0] FNC_OR      = 3'b110;
    localparam logic [2:0] FNC_AND     = 3'b111;

    // Variant bit selecting between the paired operations
    localparam logic FNC2_ADD = 1'b0;
    localparam logic FNC2_SUB = 1'b1;
    localparam logic FNC2_SRL = 1'b0;
    localparam logic FNC2_SRA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_module.sv
// rtl/alu_module.sv - 32-bit combinational ALU shared by the arbiter
// Ports:
//   alu_a, alu_b  operands
//   alu_fnc       FNC_* function code
//   alu_fnc2      FNC2_* variant (sub / arithmetic right shift)
//   alu_out       result
module alu_module
    import alu_share_arbiter_pkg::*;
(
    input  logic [ALU_W-1:0] alu_a,
    input  logic [ALU_W-1:0] alu_b,
    input  logic [2:0]       alu_fnc,
    input  logic             alu_fnc2,
    output logic [ALU_W-1:0] alu_out
);

    // Kept apart so the arithmetic shift is evaluated in a signed context;
    // mixing it into the case arm with unsigned operands would make it logical.
    logic [ALU_W-1:0] sra_res;
    assign sra_res = $unsigned($signed(alu_a) >>> alu_b);

    always_comb begin
        alu_out = '0;
        case (alu_fnc)
            FNC_ADD_SUB: alu_out = alu_fnc2 ? (alu_a - alu_b) : (alu_a + alu_b);
            FNC_SLL:     alu_out = alu_a << alu_b;
            FNC_SLT:     alu_out = {{(ALU_W-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            FNC_SLTU:    alu_out = {{(ALU_W-1){1'b0}}, alu_a < alu_b};
            FNC_XOR:     alu_out = alu_a ^ alu_b;
            FNC_SRL_SRA: alu_out = alu_fnc2 ? sra_res : (alu_a >> alu_b);
            FNC_OR:      alu_out = alu_a | alu_b;
            FNC_AND:     alu_out = alu_a & alu_b;
            default:     alu_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr_grant.sv
// rtl/alu_share_arbiter_rr_grant.sv - combinational round-robin request picker
// Ports:
//   req_valid  per-requester valid
//   rr_ptr     index searched first; search proceeds upward with wrap
//   grant      one-hot grant (zero when nothing valid)
//   grant_idx  binary index of the granted requester
//   grant_any  some requester is granted
module alu_share_arbiter_rr_grant #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        j         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && req_valid[j]) begin
                grant[j]  = 1'b1;
                grant_idx = j;
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU among NUM_REQ requesters
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      per-requester request handshake (ready one-hot or zero)
//   req_a, req_b             packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_fnc, req_variant     packed function codes and variant bits
//   resp_valid/resp_ready    per-requester response handshake (valid one-hot or zero)
//   resp_data                shared result bus
//   busy                     an operation is in flight (EXEC or RESP)
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]  req_fnc,
    input  logic [NUM_REQ-1:0]    req_variant,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q;
    logic [NUM_REQ-1:0] grant_oh_q;
    logic [DATA_W-1:0]  a_q, b_q, result_q;
    logic [2:0]         fnc_q;
    logic               var_q;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [DATA_W-1:0]  alu_out;

    logic [DATA_W-1:0]  a_arr   [NUM_REQ];
    logic [DATA_W-1:0]  b_arr   [NUM_REQ];
    logic [2:0]         fnc_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]   = req_a[i*DATA_W +: DATA_W];
        assign b_arr[i]   = req_b[i*DATA_W +: DATA_W];
        assign fnc_arr[i] = req_fnc[i*3 +: 3];
    end

    alu_share_arbiter_rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    alu_module u_alu (
        .alu_a    (a_q),
        .alu_b    (b_q),
        .alu_fnc  (fnc_q),
        .alu_fnc2 (var_q),
        .alu_out  (alu_out)
    );

    // Pointer moves just past the requester that was served, so it loses
    // priority to everyone else on the next arbitration.
    assign rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // Ready is combinational from req_valid; masked during reset so nothing
    // appears accepted while the block is held in reset.
    assign req_ready  = (state_q == IDLE && rst_n) ? grant : '0;
    assign resp_valid = resp_valid_q;
    assign resp_data  = result_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            grant_oh_q   <= '0;
            a_q          <= '0;
            b_q          <= '0;
            fnc_q        <= '0;
            var_q        <= 1'b0;
            result_q     <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        a_q        <= a_arr[grant_idx];
                        b_q        <= b_arr[grant_idx];
                        fnc_q      <= fnc_arr[grant_idx];
                        var_q      <= req_variant[grant_idx];
                        grant_q    <= grant_idx;
                        grant_oh_q <= grant;
                        busy_q     <= 1'b1;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    result_q     <= alu_out;
                    resp_valid_q <= grant_oh_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    // Only the granted requester's ready can complete the response.
                    if (|(resp_ready & grant_oh_q)) begin
                        resp_valid_q <= '0;
                        busy_q       <= 1'b0;
                        rr_ptr_q     <= rr_ptr_d;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= '0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int N = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_variant;
    logic [N*W-1:0] req_a, req_b;
    logic [N*3-1:0] req_fnc;
    logic [N-1:0]   resp_valid, resp_ready;
    logic [W-1:0]   resp_data;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [2:0]  fnc;
        logic        vb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_fnc     (req_fnc),
        .req_variant (req_variant),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_ready  (resp_ready),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int r, input logic [2:0] f, input logic v,
                        input logic [31:0] a, input logic [31:0] b);
        req_fnc[r*3 +: 3] = f;
        req_variant[r]    = v;
        req_a[r*W +: W]   = a;
        req_b[r*W +: W]   = b;
    endtask

    // One isolated operation with resp_ready high: grant, EXEC, RESP at N+2, idle.
    task automatic run_op(input string name, input int r, input logic [2:0] f, input logic v,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        logic [N-1:0] oh;
        int waited;
        oh = '0;
        oh[r] = 1'b1;
        load(r, f, v, a, b);
        resp_ready = '1;
        req_valid  = oh;
        #1;
        waited = 0;
        while (req_ready !== oh && waited < 8) begin
            tick();
            waited++;
        end
        check({name, " grant"}, 32'(req_ready), 32'(oh));
        tick();
        req_valid = '0;
        check({name, " exec busy"}, 32'(busy), 32'd1);
        check({name, " exec no resp"}, 32'(resp_valid), 32'd0);
        tick();
        check({name, " resp_valid"}, 32'(resp_valid), 32'(oh));
        check({name, " resp_data"}, resp_data, exp);
        check({name, " resp busy"}, 32'(busy), 32'd1);
        tick();
        check({name, " idle busy"}, 32'(busy), 32'd0);
        check({name, " idle resp"}, 32'(resp_valid), 32'd0);
    endtask

    // Protocol properties checked every cycle away from the rising edge.
    logic [N-1:0] prev_rv = '0, prev_rr = '0;
    logic [W-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("resp_valid onehot0", 32'($onehot0(resp_valid)), 32'd1);
            check("req_ready onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (prev_rv != '0 && (prev_rv & prev_rr) == '0) begin
                check("resp_data hold", resp_data, prev_data);
                check("resp_valid hold", 32'(resp_valid), 32'(prev_rv));
            end
            prev_rv   = resp_valid;
            prev_rr   = resp_ready;
            prev_data = resp_data;
        end else begin
            prev_rv = '0;
        end
    end

    initial begin
        int gseq [4];
        int ngrant, cnt0, cnt1;

        vecs[0]  = '{"slt",    FNC_SLT,     1'b0,     32'hFFFF_FFFF, 32'd1,         32'd1};
        vecs[1]  = '{"sltu",   FNC_SLTU,    1'b0,     32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[2]  = '{"xor",    FNC_XOR,     1'b0,     32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0};
        vecs[3]  = '{"add_wr", FNC_ADD_SUB, FNC2_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[4]  = '{"sub_wr", FNC_ADD_SUB, FNC2_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF};
        vecs[5]  = '{"sll31",  FNC_SLL,     1'b0,     32'd1,         32'd31,        32'h8000_0000};
        vecs[6]  = '{"sll32",  FNC_SLL,     1'b0,     32'd1,         32'd32,        32'd0};
        vecs[7]  = '{"srl",    FNC_SRL_SRA, FNC2_SRL, 32'h8000_0000, 32'd4,         32'h0800_0000};
        vecs[8]  = '{"sra",    FNC_SRL_SRA, FNC2_SRA, 32'h8000_0000, 32'd4,         32'hF800_0000};
        vecs[9]  = '{"sra40",  FNC_SRL_SRA, FNC2_SRA, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF};
        vecs[10] = '{"or",     FNC_OR,      1'b0,     32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
        vecs[11] = '{"and",    FNC_AND,     1'b0,     32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00};

        rst_n       = 1'b0;
        req_valid   = '0;
        resp_ready  = '0;
        req_a       = '0;
        req_b       = '0;
        req_fnc     = '0;
        req_variant = '0;
        tick();
        tick();
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request: 5 - 7
        run_op("single", 0, FNC_ADD_SUB, FNC2_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);

        // Function table, spread over the requesters
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, i % N, vecs[i].fnc, vecs[i].vb, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Serve requester 2 so the pointer sits at 0 before contention
        run_op("pre", 2, FNC_OR, 1'b0, 32'd1, 32'd2, 32'd3);

        // Contention: req0 and req1 stream continuously, resp_ready high
        load(0, FNC_ADD_SUB, FNC2_ADD, 32'd10, 32'd1);
        load(1, FNC_XOR, 1'b0, 32'hAAAA_0000, 32'h0000_FFFF);
        resp_ready = '1;
        req_valid  = 3'b011;
        ngrant = 0;
        cnt0   = 0;
        cnt1   = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (resp_valid == 3'b001) begin
                cnt0++;
                check("cont data0", resp_data, 32'd11);
            end else if (resp_valid == 3'b010) begin
                cnt1++;
                check("cont data1", resp_data, 32'hAAAA_FFFF);
            end else if (resp_valid != '0) begin
                check("cont resp_valid", 32'(resp_valid), 32'd0);
            end
            if (req_ready != '0 && ngrant < 4) begin
                gseq[ngrant] = (req_ready == 3'b001) ? 0 : (req_ready == 3'b010) ? 1 : 99;
                ngrant++;
            end
            tick();
            if (ngrant >= 4) req_valid = '0;
        end
        check("cont grants", 32'(ngrant), 32'd4);
        check("cont g0", gseq[0], 32'd0);
        check("cont g1", gseq[1], 32'd1);
        check("cont g2", gseq[2], 32'd0);
        check("cont g3", gseq[3], 32'd1);
        check("cont cnt0", cnt0, 32'd2);
        check("cont cnt1", cnt1, 32'd2);

        // Backpressure: req1 SRA held in RESP while req0 waits
        load(1, FNC_SRL_SRA, FNC2_SRA, 32'h8000_0000, 32'd4);
        load(0, FNC_ADD_SUB, FNC2_ADD, 32'd3, 32'd4);
        resp_ready = 3'b101;
        req_valid  = 3'b010;
        #1;
        check("bp grant1", 32'(req_ready), 32'b010);
        tick();
        req_valid = 3'b001;
        #1;
        check("bp exec ready", 32'(req_ready), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp resp_valid", 32'(resp_valid), 32'b010);
            check("bp resp_data", resp_data, 32'hF800_0000);
            check("bp req0 blocked", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 3'b111;
        tick();
        check("bp req0 granted", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        tick();
        check("bp req0 resp", 32'(resp_valid), 32'b001);
        check("bp req0 data", resp_data, 32'd7);
        tick();

        // Reset in EXEC with req_valid still high
        load(0, FNC_ADD_SUB, FNC2_ADD, 32'd100, 32'd23);
        req_valid = 3'b001;
        #1;
        tick();
        check("rst pre busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_data", resp_data, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst no stale resp", 32'(resp_valid), 32'd0);
            check("rst idle busy", 32'(busy), 32'd0);
        end
        run_op("fresh", 0, FNC_ADD_SUB, FNC2_SUB, 32'd50, 32'd8, 32'd42);

        // Pointer wrap: serve 2, then 0 wins from ptr 0, then 1 wins from ptr 1
        run_op("w2", 2, FNC_AND, 1'b0, 32'hFF, 32'h0F, 32'h0F);
        load(0, FNC_ADD_SUB, FNC2_ADD, 32'd2, 32'd2);
        load(1, FNC_ADD_SUB, FNC2_ADD, 32'd9, 32'd9);
        req_valid = 3'b111;
        #1;
        check("wrap grant0", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        tick();
        check("wrap resp0", 32'(resp_valid), 32'b001);
        check("wrap data0", resp_data, 32'd4);
        tick();
        req_valid = 3'b111;
        #1;
        check("wrap grant1", 32'(req_ready), 32'b010);
        req_valid = '0;
        #1;
        check("idle no ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle busy", 32'(busy), 32'd0);
            check("idle ready", 32'(req_ready), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational ALU (the core's alu_module) between NUM_REQ requesters, such as the execute stage and a CSR/address-generation helper. Each requester has its own valid/ready request channel and valid/ready response channel. Requests are granted round-robin and run one at a time; only one operation is outstanding. Operands are registered before the ALU and the result is registered after it, so the ALU sits between two flop stages on a clean timing path.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 32, operand/result width; fixed to 32 because the ALU is 32-bit

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester request accept (one-hot or zero)
req_a  input  NUM_REQ*DATA_W  operand A, requester i at bits [i*32 +: 32]
req_b  input  NUM_REQ*DATA_W  operand B, same packing
req_fnc  input  NUM_REQ*3  ALU function (FNC_* encoding), packed
req_variant  input  NUM_REQ  variant bit (FNC2_ADD/SUB, FNC2_SRL/SRA)
resp_valid  output  NUM_REQ  one-hot response valid to the granted requester
resp_data  output  DATA_W  result, shared bus, meaningful when any resp_valid
resp_ready  input  NUM_REQ  per-requester response accept
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0.
  - Operand, function and result registers cleared.
  - req_ready=0, resp_valid=0, resp_data=0, busy=0.
  - Takes effect immediately, including mid-operation: the in-flight request and result are discarded, no response is issued, and the requester must reissue.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = first i with req_valid[i], searching from rr_ptr upward with wrap (modulo NUM_REQ).
  - req_ready[grant]=1 combinationally, all other bits 0. If no valid, req_ready=0.
  - On handshake: capture a, b, fnc, variant and grant index into registers, then go to EXEC.
  - req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- EXEC (exactly 1 cycle):
  - ALU inputs are driven from the operand registers.
  - alu_out is registered into result_q; go to RESP.
  - req_ready=0.
- RESP:
  - resp_valid[grant_q]=1 and resp_data=result_q, both held stable until resp_ready[grant_q]=1.
  - On that handshake: rr_ptr = (grant_q+1) mod NUM_REQ, go to IDLE.
  - resp_ready from non-granted requesters is ignored. No new request is accepted in RESP.
- Latency:
  - Request handshake in cycle N gives resp_valid in cycle N+2.
  - With resp_ready tied high, one operation completes every 3 cycles.
- Back-to-back from the same requester: after its response, rr_ptr has moved past it, so any other valid requester wins the next grant (fairness). If no other requester is valid, the same requester is granted again.
- Simultaneous requests in IDLE: exactly one is granted, chosen by rr_ptr. The losers keep req_valid high and their inputs stable; this is their protocol obligation.
- Arithmetic follows the ALU's semantics exactly:
  - Add/sub wrap modulo 2^32.
  - SLT is signed and SLTU unsigned; both produce 0/1.
  - SRA is arithmetic. The shift amount is passed unmasked.
  - An undefined fnc cannot occur with a 3-bit field, since all 8 codes are defined.
- Assertions (verification): resp_valid and req_ready are each one-hot-or-zero; resp_data stays stable while resp_valid is high and resp_ready is low.

Decomposition:
- Shared package / Opcode.vh holds:
  - FNC_* function codes: ADD_SUB=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL_SRA=101, OR=110, AND=111.
  - FNC2_* variant codes: ADD=0, SUB=1, SRL=0, SRA=1.
  - The arbiter state encodings: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One sub-module is natural: rr_grant, a combinational round-robin priority picker with inputs (req_valid, rr_ptr) and outputs (grant one-hot, grant index).
- alu_module is instantiated unchanged.

Test Plan:
- Single request: req0 fnc=000 variant=1, a=5, b=7, accepted at cycle N -> resp_valid[0] at N+2 with resp_data=0xFFFFFFFE; busy high for 2 cycles, then low once resp_ready.
- Contention: req0 and req1 valid together, each with continuous streams, resp_ready tied high -> grants alternate 0,1,0,1; after 4 ops each requester has 2 responses; req_ready never asserted to both at once.
- Backpressure: req1 SRA (fnc=101, variant=1) a=0x80000000, b=4, resp_ready[1]=0 for 5 cycles -> resp_data held at 0xF8000000 with resp_valid[1] high throughout; req0 is not accepted until the handshake.
- Compares: SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0; XOR 0xF0F0F0F0 with 0xFFFF0000 -> 0x0F0FF0F0.
- Reset mid-op: assert rst_n=0 in EXEC -> all outputs 0 immediately. Release, then reissue -> the correct fresh result, with no stale response from the dropped op.
- Idle/ptr wrap, NUM_REQ=3: serve requesters 2 then 0 -> rr_ptr wraps 0→1; no valid requests -> req_ready=0 and state stays IDLE.
